// File: rtl/uart_calc_master_ctrl.sv
// Host-side UART calculator transaction controller: sends a 5-byte request and collects a 16-bit reply.
// Optional checksum byte on both directions is enabled by defining UART_CALC_CHECKSUM_EN.
module uart_calc_master_ctrl #(
   parameter int unsigned INTER_BYTE_DELAY = 1000,
   parameter int unsigned RESP_TIMEOUT     = 10_000_000,
   parameter int unsigned TX_BUSY_GUARD    = 100
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        start,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   input  logic [7:0]  opcode,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   input  logic [7:0]  rx_data,
   input  logic        rx_ready,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        timeout_err,
`ifdef UART_CALC_CHECKSUM_EN
   output logic        chk_err,
`endif
   output logic [3:0]  state_dbg
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_LOAD      = 4'd1,
      S_SEND      = 4'd2,
      S_WAIT_BUSY = 4'd3,
      S_WAIT_TX   = 4'd4,
      S_GAP       = 4'd5,
      S_WAIT_RX0  = 4'd6,
      S_WAIT_RX1  = 4'd7,
      S_DONE      = 4'd8,
      S_ERR       = 4'd9,
      S_WAIT_RX2  = 4'd10
   } state_t;

`ifdef UART_CALC_CHECKSUM_EN
   localparam logic [2:0] LAST_IDX = 3'd5;
`else
   localparam logic [2:0] LAST_IDX = 3'd4;
`endif

   state_t      state, state_nxt;
   logic [31:0] cnt, cnt_nxt;
   logic [2:0]  idx, idx_nxt;

   logic [15:0] a_q, b_q, shadow;
   logic [7:0]  opc_q;
   logic [7:0]  frame_byte;

`ifdef UART_CALC_CHECKSUM_EN
   logic        chk_bad;

   function automatic logic [7:0] xor_fold5(input logic [15:0] a, input logic [15:0] b,
                                            input logic [7:0] op);
      return a[7:0] ^ a[15:8] ^ b[7:0] ^ b[15:8] ^ op;
   endfunction
`endif

   always_comb begin
      case (idx)
         3'd0:    frame_byte = a_q[7:0];
         3'd1:    frame_byte = a_q[15:8];
         3'd2:    frame_byte = b_q[7:0];
         3'd3:    frame_byte = b_q[15:8];
`ifdef UART_CALC_CHECKSUM_EN
         3'd5:    frame_byte = xor_fold5(a_q, b_q, opc_q);
`endif
         default: frame_byte = opc_q;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_LOAD;
               idx_nxt   = '0;
               cnt_nxt   = '0;
            end
         end
         S_LOAD: state_nxt = S_SEND;
         S_SEND: begin
            state_nxt = S_WAIT_BUSY;
            cnt_nxt   = '0;
         end
         // A transmitter that never acknowledges is treated as having sent the byte.
         S_WAIT_BUSY: begin
            if (tx_busy || (cnt + 1 >= TX_BUSY_GUARD)) begin
               state_nxt = S_WAIT_TX;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1;
            end
         end
         S_WAIT_TX: begin
            if (!tx_busy) begin
               state_nxt = S_GAP;
               cnt_nxt   = '0;
            end
         end
         S_GAP: begin
            if (cnt + 1 >= INTER_BYTE_DELAY) begin
               cnt_nxt = '0;
               if (idx == LAST_IDX) begin
                  state_nxt = S_WAIT_RX0;
               end else begin
                  idx_nxt   = idx + 3'd1;
                  state_nxt = S_LOAD;
               end
            end else begin
               cnt_nxt = cnt + 1;
            end
         end
         // The received byte takes priority over the timeout terminal count.
         S_WAIT_RX0, S_WAIT_RX1, S_WAIT_RX2: begin
            if (rx_ready) begin
               cnt_nxt = '0;
               if (state == S_WAIT_RX0) begin
                  state_nxt = S_WAIT_RX1;
`ifdef UART_CALC_CHECKSUM_EN
               end else if (state == S_WAIT_RX1) begin
                  state_nxt = S_WAIT_RX2;
`endif
               end else begin
                  state_nxt = S_DONE;
               end
            end else if (cnt + 1 >= RESP_TIMEOUT) begin
               state_nxt = S_ERR;
            end else begin
               cnt_nxt = cnt + 1;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         S_ERR:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state <= S_IDLE;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
      end
   end

   // Registered outputs: busy tracks the next state so it drops on the same edge done rises.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         tx_data     <= '0;
         tx_start    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         result      <= '0;
         timeout_err <= 1'b0;
`ifdef UART_CALC_CHECKSUM_EN
         chk_err     <= 1'b0;
`endif
      end else begin
         tx_start <= (state_nxt == S_SEND);
         busy     <= (state_nxt != S_IDLE);
         done     <= (state == S_DONE) || (state == S_ERR);
         if (state == S_LOAD) begin
            tx_data <= frame_byte;
         end
         if (state == S_DONE) begin
            timeout_err <= 1'b0;
`ifdef UART_CALC_CHECKSUM_EN
            chk_err <= chk_bad;
            if (!chk_bad) begin
               result <= shadow;
            end
`else
            result <= shadow;
`endif
         end
         if (state == S_ERR) begin
            timeout_err <= 1'b1;
`ifdef UART_CALC_CHECKSUM_EN
            chk_err     <= 1'b0;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_IDLE && start) begin
         a_q   <= op_a;
         b_q   <= op_b;
         opc_q <= opcode;
      end
      if (state == S_WAIT_RX0 && rx_ready) begin
         shadow[7:0] <= rx_data;
      end
      if (state == S_WAIT_RX1 && rx_ready) begin
         shadow[15:8] <= rx_data;
      end
`ifdef UART_CALC_CHECKSUM_EN
      if (state == S_WAIT_RX2 && rx_ready) begin
         chk_bad <= (rx_data != (shadow[7:0] ^ shadow[15:8]));
      end
`endif
   end

   assign state_dbg = state;

endmodule

// File: doc/uart_calc_master_ctrl.md
Name: uart_calc_master_ctrl

Overview:
- Host-side (ME) transaction controller for the UART RPN calculator link.
- Takes one calculator request (operand A, operand B, opcode) and serialises it as bytes to a uart_basic transmitter.
- Then collects the 2-byte 16-bit result the calculator returns on the uart_basic receiver.
- Sits between host logic (switches/buttons or test sequencer) and uart_basic on the master board.

Parameters:
- INTER_BYTE_DELAY, 1000: idle clock cycles inserted after each transmitted byte before the next tx_start.
- RESP_TIMEOUT, 10_000_000: max clock cycles waiting for each response byte before aborting.
- TX_BUSY_GUARD, 100: max cycles to wait for tx_busy to rise after tx_start; on expiry, treat the byte as sent.

Ports:
- clk  in  1  system clock (100 MHz)
- resetN  in  1  synchronous active-low reset
- start  in  1  one-cycle request pulse; sampled only in IDLE
- op_a  in  16  first operand
- op_b  in  16  second operand
- opcode  in  8  ALU operation code
- tx_data  out  8  byte to uart_basic
- tx_start  out  1  one-cycle transmit pulse to uart_basic
- tx_busy  in  1  uart_basic transmitter busy
- rx_data  in  8  byte from uart_basic
- rx_ready  in  1  one-cycle valid strobe from uart_basic
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of transaction
- result  out  16  last valid response, held until next success
- timeout_err  out  1  registered with done; 1 = response timed out
- state_dbg  out  4  current state encoding, for LEDs

Behaviour:
- Reset (resetN=0 at clk edge): state IDLE; tx_start=0; tx_data=0; busy=0; done=0; result=0; timeout_err=0; all counters 0. Reset mid-transaction aborts immediately; no done pulse.
- Frame order (TX), 5 bytes: op_a[7:0], op_a[15:8], op_b[7:0], op_b[15:8], opcode.
- Response (RX), 2 bytes, LSB first: result[7:0], then result[15:8].
- Capture: op_a, op_b and opcode are latched on the start cycle. Later input changes have no effect.
- State machine:
  - IDLE -> LOAD on start; byte index=0.
  - LOAD: drive tx_data = frame[index] for one cycle (register settle) -> SEND.
  - SEND: tx_start=1 for exactly one cycle -> WAIT_BUSY.
  - WAIT_BUSY: -> WAIT_TX when tx_busy=1, or when the guard counter reaches TX_BUSY_GUARD.
  - WAIT_TX: -> GAP when tx_busy=0.
  - GAP: count INTER_BYTE_DELAY cycles. Then, if index<4, increment index -> LOAD; else -> WAIT_RX0 with timeout counter cleared.
  - WAIT_RX0: rx_ready latches rx_data into the low byte of a shadow register -> WAIT_RX1 with timeout cleared.
  - WAIT_RX1: rx_ready latches the high byte -> DONE.
  - DONE: result <= shadow; timeout_err=0; done=1 for one cycle -> IDLE.
  - ERR: entered from either WAIT_RX state when the counter reaches RESP_TIMEOUT-1. result unchanged; timeout_err=1; done=1 for one cycle -> IDLE.
- busy=1 in every state except IDLE; it falls in the same cycle done is asserted.
- start while busy is ignored, with no queueing. start and a reset cycle together: reset wins.
- rx_ready outside the WAIT_RX states (including during TX) is discarded. A rx_ready on the same cycle as the timeout terminal count is accepted; the byte wins.
- timeout_err holds its value until the next done.
- tx_data holds the last byte between transmissions.
- Latency without timeout: 5 x (2 + uart byte time + INTER_BYTE_DELAY) cycles + response time + 1.

Optional Feature:
- Macro UART_CALC_CHECKSUM_EN.
- When defined:
  - TX appends a 6th byte = XOR of the 5 frame bytes.
  - RX expects a 3rd byte = result[7:0] XOR result[15:8].
  - On mismatch: result is not updated, done pulses, and an extra output port chk_err (1 bit) is 1 for that transaction (else 0).
  - state_dbg gains a WAIT_RX2 encoding.
- When undefined: 5-byte frame, 2-byte response, no chk_err port.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0, state_dbg=IDLE, no tx_start for 100 cycles.
- start with op_a=0x1234, op_b=0x00AB, opcode=0x2B; uart loopback model -> tx_start pulses 5 times with tx_data 0x34, 0x12, 0xAB, 0x00, 0x2B. Each pulse is at least INTER_BYTE_DELAY cycles after the preceding tx_busy fall.
- After the frame, model returns 0xDF then 0x12 -> done one cycle, result=0x12DF, timeout_err=0, busy low the same cycle.
- After the frame, model returns only 0x55 -> at RESP_TIMEOUT (set 2000 in bench) cycles after 0x55: done=1, timeout_err=1, result keeps previous 0x12DF.
- start pulsed again mid-frame and rx_ready 0xFF injected during TX -> no restart, byte ignored, transaction completes with correct result.
- resetN low for 1 cycle during WAIT_TX of byte 3 -> next cycle IDLE, busy=0, no done; a new start sends the full 5-byte frame from byte 0.
